// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing constants and shared pixel feeder types
package vga_timing_pkg;

  // 800x524 frame geometry shared with the pixel generator
  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL   = 524;

  // System clock runs at four times the pixel rate
  localparam int CLK_DIV   = 4;

  typedef enum logic [1:0] {
    HUNT,
    ARMED,
    STREAM
  } feeder_state_t;

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } pix_word_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO with registered occupancy and combinational head
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             push_ok,  pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; simultaneous push and pop leaves the level unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vga_pixel_feeder.sv
// rtl/vga_pixel_feeder.sv - frame-aligned pixel byte feeder for the VGA generator (FEEDER_STATS_EN adds counters)
module vga_pixel_feeder #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int         H_TOTAL    = vga_timing_pkg::H_TOTAL,
  parameter int         V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int         V_TOTAL    = vga_timing_pkg::V_TOTAL,
  parameter logic [7:0] FILL_COLOR = 8'h00
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [7:0]                    inData,
  input  logic                          inSof,
  input  logic                          inValid,
  output logic                          inReady,
  output logic [7:0]                    pixelOut,
  output logic                          synced,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]                   underflowCount,
  output logic [15:0]                   misalignCount
`endif
);

  import vga_timing_pkg::*;

  localparam int PHASE_W = $clog2(CLK_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  feeder_state_t      state_q, state_d;
  logic [7:0]         pix_q,   pix_d;
  logic               underflow_q, underflow_d;
  logic               misalign_evt;

  logic               tick;
  logic               visible;
  logic               at_origin;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [8:0]         fifo_head;
  pix_word_t          head_w;
  pix_word_t          push_w;

  assign tick      = (phase_q == PHASE_W'(CLK_DIV - 1));
  assign visible   = (h_cnt_q < HW'(H_VISIBLE)) && (v_cnt_q < VW'(V_VISIBLE));
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

  assign push_w    = '{sof: inSof, data: inData};
  assign head_w    = pix_word_t'(fifo_head);
  assign inReady   = !fifo_full;
  assign fifo_push = inValid && inReady;

  assign pixelOut  = pix_q;
  assign synced    = (state_q == STREAM);
  assign underflow = underflow_q;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_word_t))
  ) u_fifo (
    .clk       (clock),
    .rst_n     (resetN),
    .push      (fifo_push),
    .push_data (push_w),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifoLevel),
    .head      (fifo_head)
  );

  // Pixel-slot timing: phase divides the clock, counters step once per tick
  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  // Alignment FSM: discard until SOF, wait for frame origin, then feed one byte per visible slot
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    underflow_d  = 1'b0;
    misalign_evt = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      HUNT: begin
        if (!fifo_empty) begin
          if (head_w.sof) state_d  = ARMED;
          else            fifo_pop = 1'b1;
        end
        if (tick) pix_d = FILL_COLOR;
      end
      ARMED: begin
        if (tick) begin
          if (at_origin && !fifo_empty) begin
            fifo_pop = 1'b1;
            pix_d    = head_w.data;
            state_d  = STREAM;
          end else begin
            pix_d    = FILL_COLOR;
          end
        end
      end
      STREAM: begin
        if (tick) begin
          if (!visible) begin
            pix_d = FILL_COLOR;
          end else if (fifo_empty) begin
            pix_d       = FILL_COLOR;
            underflow_d = 1'b1;
            state_d     = HUNT;
          end else if (!head_w.sof || at_origin) begin
            fifo_pop = 1'b1;
            pix_d    = head_w.data;
          end else begin
            // SOF arrived early: keep it for the next frame origin
            pix_d        = FILL_COLOR;
            misalign_evt = 1'b1;
            state_d      = ARMED;
          end
        end
      end
      default: begin
        state_d = HUNT;
        pix_d   = FILL_COLOR;
      end
    endcase
  end

  // Timing, FSM and output registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      phase_q     <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      state_q     <= HUNT;
      pix_q       <= FILL_COLOR;
      underflow_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      state_q     <= state_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [15:0] ma_cnt_q, ma_cnt_d;

  assign underflowCount = uf_cnt_q;
  assign misalignCount  = ma_cnt_q;

  // Saturating event counters
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    ma_cnt_d = ma_cnt_q;
    if (underflow_d  && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
    if (misalign_evt && (ma_cnt_q != 16'hFFFF)) ma_cnt_d = ma_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      uf_cnt_q <= '0;
      ma_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
      ma_cnt_q <= ma_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb/tb_vga_pixel_feeder.sv - self-checking bench for vga_pixel_feeder on a reduced 12x6 frame
module tb_vga_pixel_feeder;

  localparam int HV = 8;
  localparam int HT = 12;
  localparam int VV = 4;
  localparam int VT = 6;
  localparam int DEPTH = 16;
  localparam int FRAME = HT * VT;

  logic       clock = 1'b0;
  logic       resetN;
  logic [7:0] inData;
  logic       inSof;
  logic       inValid;
  logic       inReady;
  logic [7:0] pixelOut;
  logic       synced;
  logic       underflow;
  logic [4:0] fifoLevel;
`ifdef FEEDER_STATS_EN
  logic [15:0] underflowCount;
  logic [15:0] misalignCount;
`endif

  always #5 clock = ~clock;

  vga_pixel_feeder #(
    .FIFO_DEPTH (DEPTH),
    .H_VISIBLE  (HV),
    .H_TOTAL    (HT),
    .V_VISIBLE  (VV),
    .V_TOTAL    (VT),
    .FILL_COLOR (8'h00)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .inData    (inData),
    .inSof     (inSof),
    .inValid   (inValid),
    .inReady   (inReady),
    .pixelOut  (pixelOut),
    .synced    (synced),
    .underflow (underflow),
    .fifoLevel (fifoLevel)
`ifdef FEEDER_STATS_EN
    ,
    .underflowCount (underflowCount),
    .misalignCount  (misalignCount)
`endif
  );

  typedef struct packed {
    logic       sof;
    logic [7:0] data;
  } word_t;

  typedef struct {
    int         slot;
    logic [7:0] pix;
    logic       syn;
    logic       uf;
  } vec_t;

  word_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    pcnt   = 0;
  int    slot   = -1;
  int    pushed = 0;
  int    uf_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h slot=%0d", name, act, exp, slot);
    end
  endtask

  // producer: offers queue head at each negedge, commits when the FIFO has room
  always @(negedge clock) begin
    if (resetN && q.size() > 0) begin
      inValid = 1'b1;
      inSof   = q[0].sof;
      inData  = q[0].data;
      if (inReady) begin
        void'(q.pop_front());
        pushed++;
      end
    end else begin
      inValid = 1'b0;
      inSof   = 1'b0;
      inData  = 8'h00;
    end
  end

  always @(negedge clock) if (resetN && underflow) uf_seen++;

  always @(posedge clock) begin
    if (!resetN) pcnt <= 0;
    else         pcnt <= pcnt + 1;
  end

  task automatic put(input logic sof, input logic [7:0] d);
    q.push_back('{sof: sof, data: d});
  endtask

  task automatic do_reset();
    resetN  = 1'b0;
    q.delete();
    repeat (2) @(negedge clock);
    uf_seen = 0;
    resetN  = 1'b1;
    slot    = -1;
  endtask

  // advance to 1 time unit after the tick edge of the next pixel slot
  task automatic next_slot();
    int target;
    int guard;
    target = 4 * (slot + 2);
    guard  = 0;
    while (pcnt < target && guard < 64) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (pcnt != target) begin
      errors++;
      $display("FAIL slot_align actual=%0d expected=%0d", pcnt, target);
    end
    slot++;
  endtask

  function automatic bit is_vis(input int s);
    return ((s % HT) < HV) && (((s / HT) % VT) < VV);
  endfunction

  vec_t tbl [11];
  int   bad;
  int   vi;
  int   n0;

  initial begin
    tbl[0]  = '{0,  8'hE0, 1'b1, 1'b0};
    tbl[1]  = '{1,  8'h1C, 1'b1, 1'b0};
    tbl[2]  = '{7,  8'h1C, 1'b1, 1'b0};
    tbl[3]  = '{8,  8'h00, 1'b1, 1'b0};
    tbl[4]  = '{11, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{12, 8'h1C, 1'b1, 1'b0};
    tbl[6]  = '{43, 8'h1C, 1'b1, 1'b0};
    tbl[7]  = '{44, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{48, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{71, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{72, 8'h00, 1'b0, 1'b1};

    resetN = 1'b0; inValid = 1'b0; inSof = 1'b0; inData = 8'h00;

    // test 1: reset values, then two idle frames
    repeat (2) @(negedge clock);
    chk("rst_pixel", pixelOut, 8'h00);
    chk("rst_synced", synced, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_inready", inReady, 1'b1);
    chk("rst_level", fifoLevel, 5'd0);
    do_reset();
    bad = 0;
    for (int s = 0; s < 2 * FRAME; s++) begin
      next_slot();
      if (pixelOut !== 8'h00 || synced !== 1'b0) bad++;
    end
    chk("t1_idle_outputs", bad, 0);
    chk("t1_no_underflow", uf_seen, 0);

    // test 2: full frame stream, table spot checks plus whole-frame rule
    do_reset();
    put(1'b1, 8'hE0);
    repeat (HV * VV - 1) put(1'b0, 8'h1C);
    bad = 0; vi = 0;
    for (int s = 0; s <= FRAME; s++) begin
      next_slot();
      if (slot < FRAME) begin
        if (pixelOut !== (is_vis(slot) ? ((slot == 0) ? 8'hE0 : 8'h1C) : 8'h00) || synced !== 1'b1) bad++;
      end
      if (slot == FRAME - 1) chk("t2_no_underflow", uf_seen, 0);
      if (vi < 11 && tbl[vi].slot == slot) begin
        chk($sformatf("t2_pix_s%0d", slot), pixelOut, tbl[vi].pix);
        chk($sformatf("t2_syn_s%0d", slot), synced, tbl[vi].syn);
        chk($sformatf("t2_uf_s%0d", slot), underflow, tbl[vi].uf);
        vi++;
      end
    end
    chk("t2_frame_rule", bad, 0);

    // test 3: five junk bytes discarded, SOF waits for the next frame origin
    do_reset();
    for (int i = 0; i < 5; i++) put(1'b0, 8'h11 + 8'(i));
    put(1'b1, 8'h03);
    bad = 0;
    for (int s = 0; s <= FRAME; s++) begin
      next_slot();
      if (slot < FRAME && (pixelOut !== 8'h00 || synced !== 1'b0)) bad++;
      if (slot == 2) chk("t3_level_sof_kept", fifoLevel, 5'd1);
    end
    chk("t3_wait_fill", bad, 0);
    chk("t3_origin_pixel", pixelOut, 8'h03);
    chk("t3_synced_rise", synced, 1'b1);

    // test 4: producer stalls mid-line, underflow pulse and resync
    do_reset();
    put(1'b1, 8'hA1);
    for (int i = 0; i < 4; i++) put(1'b0, 8'hA2 + 8'(i));
    for (int s = 0; s < 5; s++) next_slot();
    chk("t4_last_good", pixelOut, 8'hA5);
    chk("t4_synced_before", synced, 1'b1);
    next_slot();
    chk("t4_uf_pulse", underflow, 1'b1);
    chk("t4_uf_pixel", pixelOut, 8'h00);
    chk("t4_uf_synced", synced, 1'b0);
    @(posedge clock); #1;
    chk("t4_uf_one_clock", underflow, 1'b0);
    put(1'b1, 8'h55);
    repeat (HV * VV - 1) put(1'b0, 8'hAA);
    bad = 0;
    for (int s = 6; s <= FRAME + 1; s++) begin
      next_slot();
      if (slot < FRAME && (pixelOut !== 8'h00 || synced !== 1'b0)) bad++;
      if (slot == FRAME - 1) begin
        chk("t4_single_pulse", uf_seen, 1);
`ifdef FEEDER_STATS_EN
        chk("t4_underflow_count", underflowCount, 16'd1);
`endif
      end
      if (slot == FRAME) chk("t4_resync_pixel", pixelOut, 8'h55);
    end
    chk("t4_hunt_fill", bad, 0);
    chk("t4_next_pixel", pixelOut, 8'hAA);

    // test 5: FIFO fills while ARMED; one pop admits exactly one push
    do_reset();
    next_slot();
    put(1'b1, 8'h99);
    repeat (20) put(1'b0, 8'h22);
    while (slot < 10) next_slot();
    chk("t5_level_full", fifoLevel, 5'd16);
    chk("t5_ready_low", inReady, 1'b0);
    chk("t5_valid_held", inValid, 1'b1);
    while (slot < FRAME) next_slot();
    chk("t5_origin_pixel", pixelOut, 8'h99);
    chk("t5_level_after_pop", fifoLevel, 5'd15);
    n0 = pushed;
    repeat (2) begin @(posedge clock); #1; end
    chk("t5_one_push", pushed - n0, 1);
    chk("t5_level_refull", fifoLevel, 5'd16);
    chk("t5_ready_relow", inReady, 1'b0);

    // test 7: early SOF inside a line is held for the next frame origin
    do_reset();
    put(1'b1, 8'hE0);
    repeat (3) put(1'b0, 8'h1C);
    put(1'b1, 8'h66);
    repeat (HV * VV - 1) put(1'b0, 8'h33);
    bad = 0;
    for (int s = 0; s <= FRAME + 1; s++) begin
      next_slot();
      if (slot == 3) chk("t7_pre_misalign", pixelOut, 8'h1C);
      if (slot == 4) begin
        chk("t7_misalign_pixel", pixelOut, 8'h00);
        chk("t7_misalign_synced", synced, 1'b0);
      end
      if (slot > 4 && slot < FRAME && (pixelOut !== 8'h00 || synced !== 1'b0)) bad++;
      if (slot == FRAME) chk("t7_realign_pixel", pixelOut, 8'h66);
    end
    chk("t7_armed_fill", bad, 0);
    chk("t7_stream_next", pixelOut, 8'h33);
    chk("t7_no_underflow", uf_seen, 0);
`ifdef FEEDER_STATS_EN
    chk("t7_misalign_count", misalignCount, 16'd1);
`endif

    // test 6: asynchronous reset in the middle of STREAM
    do_reset();
    put(1'b1, 8'hE0);
    repeat (HV * VV - 1) put(1'b0, 8'h1C);
    while (slot < 13) next_slot();
    chk("t6_pre_pixel", pixelOut, 8'h1C);
    chk("t6_pre_synced", synced, 1'b1);
    chk("t6_pre_level_nonzero", (fifoLevel != 5'd0), 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    chk("t6_rst_pixel", pixelOut, 8'h00);
    chk("t6_rst_synced", synced, 1'b0);
    chk("t6_rst_level", fifoLevel, 5'd0);
    chk("t6_rst_ready", inReady, 1'b1);
    chk("t6_rst_underflow", underflow, 1'b0);
`ifdef FEEDER_STATS_EN
    chk("t6_rst_ufcount", underflowCount, 16'd0);
`endif
    do_reset();
    put(1'b1, 8'h77);
    next_slot();
    chk("t6_restart_origin", pixelOut, 8'h77);
    chk("t6_restart_synced", synced, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
